core_if_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer placed between the IF-stage PC generator and the instruction memory bus. Accepts fetch addresses by valid/ready, issues them as bus commands with up to `MAX_OUTST` requests in flight, tags in-order responses with their PC, and buffers them for the IFU. On a pipeline flush it drops all buffered instructions and silently discards the responses still in flight, so stale instructions never reach decode.

---
 rtl/core_if_fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_core_if_fetch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : core_if_fetch_ctrl
// Brief  : IF fetch sequencer - credit-limited bus issue, PC tagging of
//          in-order responses, response buffer, flush with in-flight discard.
// Rev    : 1.0 - initial release
// ============================================================================
module core_if_fetch_ctrl #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pc_valid,
  output logic                  o_pc_ready,
  input  logic [PC_WIDTH-1:0]   i_pc,
  output logic                  o_icb_cmd_valid,
  input  logic                  i_icb_cmd_ready,
  output logic [PC_WIDTH-1:0]   o_icb_cmd_addr,
  input  logic                  i_icb_rsp_valid,
  output logic                  o_icb_rsp_ready,
  input  logic [INST_WIDTH-1:0] i_icb_rsp_rdata,
  input  logic                  i_icb_rsp_err,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_inst_pc,
  output logic                  o_inst_err,
  input  logic                  i_pipe_flush_req,
  output logic                  o_busy
);

  localparam int                 c_CNT_W   = $clog2(MAX_OUTST + 1);
  localparam int                 c_PTR_W   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_OUTST);
  localparam logic [c_CNT_W:0]   c_SUM_MAX = (c_CNT_W + 1)'(MAX_OUTST);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_LST = c_PTR_W'(MAX_OUTST - 1);

  logic [c_CNT_W-1:0]    r_outst_cnt, r_disc_cnt, r_fifo_cnt;
  logic [c_PTR_W-1:0]    r_tq_wr, r_tq_rd, r_df_wr, r_df_rd;
  logic [PC_WIDTH-1:0]   r_tq_pc   [MAX_OUTST];
  logic [INST_WIDTH-1:0] r_df_inst [MAX_OUTST];
  logic [PC_WIDTH-1:0]   r_df_pc   [MAX_OUTST];
  logic                  r_df_err  [MAX_OUTST];

  logic w_flush, w_credit, w_issue, w_rsp, w_keep, w_pop;

  function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LST) ? '0 : p + c_PTR_ONE;
  endfunction

  // Credit uses only registered counts, so a same-cycle pop never frees a slot.
  assign w_flush  = i_pipe_flush_req;
  assign w_credit = ({1'b0, r_outst_cnt} + {1'b0, r_fifo_cnt}) < c_SUM_MAX;

  assign o_icb_cmd_valid = i_pc_valid & w_credit & ~w_flush;
  assign o_icb_cmd_addr  = i_pc;
  assign o_pc_ready      = i_icb_cmd_ready & w_credit & ~w_flush;
  assign o_icb_rsp_ready = 1'b1;

  assign w_issue = o_icb_cmd_valid & i_icb_cmd_ready;
  assign w_rsp   = i_icb_rsp_valid;
  assign w_keep  = w_rsp & (r_disc_cnt == '0) & ~w_flush;
  assign w_pop   = o_inst_valid & i_inst_ready & ~w_flush;

  assign o_inst_valid = (r_fifo_cnt != '0);
  assign o_inst       = r_df_inst[r_df_rd];
  assign o_inst_pc    = r_df_pc[r_df_rd];
  assign o_inst_err   = r_df_err[r_df_rd];
  assign o_busy       = (r_outst_cnt != '0) | (r_fifo_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst_cnt <= '0;
      r_disc_cnt  <= '0;
      r_fifo_cnt  <= '0;
      r_tq_wr     <= '0;
      r_tq_rd     <= '0;
      r_df_wr     <= '0;
      r_df_rd     <= '0;
    end else begin
      r_outst_cnt <= r_outst_cnt + c_CNT_W'(w_issue) - c_CNT_W'(w_rsp);
      if (w_flush) begin
        // outst_cnt already counts older pending discards, so this stays exact
        r_disc_cnt <= r_outst_cnt - c_CNT_W'(w_rsp);
        r_fifo_cnt <= '0;
        r_tq_wr    <= '0;
        r_tq_rd    <= '0;
        r_df_wr    <= '0;
        r_df_rd    <= '0;
      end else begin
        if (w_rsp && (r_disc_cnt != '0)) begin
          r_disc_cnt <= r_disc_cnt - c_CNT_ONE;
        end
        r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(w_keep) - c_CNT_W'(w_pop);
        if (w_issue) r_tq_wr <= f_inc(r_tq_wr);
        if (w_keep) begin
          r_tq_rd <= f_inc(r_tq_rd);
          r_df_wr <= f_inc(r_df_wr);
        end
        if (w_pop) r_df_rd <= f_inc(r_df_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_tq_pc[r_tq_wr] <= i_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        r_df_inst[i] <= '0;
        r_df_pc[i]   <= '0;
        r_df_err[i]  <= 1'b0;
      end
    end else if (w_keep) begin
      r_df_inst[r_df_wr] <= i_icb_rsp_rdata;
      r_df_pc[r_df_wr]   <= r_tq_pc[r_tq_rd];
      r_df_err[r_df_wr]  <= i_icb_rsp_err;
    end
  end

  a_outst_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_issue && !w_rsp && (r_outst_cnt == c_CNT_MAX)));
  a_outst_udf: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rsp && (r_outst_cnt == '0)));
  a_fifo_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_keep && !w_pop && (r_fifo_cnt == c_CNT_MAX)));

endmodule
`default_nettype wire

// File: tb/tb_core_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_core_if_fetch_ctrl
// Brief  : Self-checking bench for core_if_fetch_ctrl (queue-based model).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_core_if_fetch_ctrl;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_pc_valid, o_pc_ready;
  logic [31:0] i_pc;
  logic        o_icb_cmd_valid, i_icb_cmd_ready;
  logic [31:0] o_icb_cmd_addr;
  logic        i_icb_rsp_valid, o_icb_rsp_ready;
  logic [31:0] i_icb_rsp_rdata;
  logic        i_icb_rsp_err;
  logic        o_inst_valid, i_inst_ready;
  logic [31:0] o_inst, o_inst_pc;
  logic        o_inst_err, i_pipe_flush_req, o_busy;

  always #5 clk = ~clk;

  core_if_fetch_ctrl #(.PC_WIDTH(32), .INST_WIDTH(32), .MAX_OUTST(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pc_valid(i_pc_valid), .o_pc_ready(o_pc_ready), .i_pc(i_pc),
    .o_icb_cmd_valid(o_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
    .o_icb_cmd_addr(o_icb_cmd_addr),
    .i_icb_rsp_valid(i_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
    .i_icb_rsp_rdata(i_icb_rsp_rdata), .i_icb_rsp_err(i_icb_rsp_err),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_inst_err(o_inst_err),
    .i_pipe_flush_req(i_pipe_flush_req), .o_busy(o_busy)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  typedef struct {
    logic        pcv;
    logic        cmdr;
    logic        flush;
    logic [31:0] pc;
    logic        e_cv;
    logic        e_pr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding count, discard count, tag list, buffer.
  ent_t        m_fifo[$];
  logic [31:0] m_tq[$];
  int          m_outst, m_disc;

  logic [31:0] src_q[$];   // PC generator backlog
  logic [31:0] bus_q[$];   // addresses the bus still owes a response for
  logic [31:0] got[$];     // PCs actually consumed from the DUT
  int          cyc, first_issue, first_valid, n_issue;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[7:0] == 8'h10) || (a[3:2] == 2'b11);
  endfunction

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    i_pc_valid = 1'b0; i_pc = '0; i_icb_cmd_ready = 1'b0;
    i_icb_rsp_valid = 1'b0; i_icb_rsp_rdata = '0; i_icb_rsp_err = 1'b0;
    i_inst_ready = 1'b0; i_pipe_flush_req = 1'b0;
  endtask

  task automatic clr_model();
    m_fifo.delete(); m_tq.delete(); m_outst = 0; m_disc = 0;
    src_q.delete(); bus_q.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr_model();
  endtask

  // One clock: drive at the negedge, check 1ns later, update model at posedge.
  task automatic step(input bit cmdr, input bit rsp_en, input bit instr, input bit flush);
    bit          pcv, rspv, credit, e_cv, e_pr, issue, pop, rerr;
    logic [31:0] pc, rdat;
    ent_t        e;
    pcv  = (src_q.size() != 0);
    pc   = pcv ? src_q[0] : ($urandom() & 32'hffff_fffc);
    rspv = rsp_en && (bus_q.size() != 0);
    rdat = rspv ? mem_data(bus_q[0]) : $urandom();
    rerr = rspv ? mem_err(bus_q[0]) : 1'b0;
    i_pc_valid = pcv; i_pc = pc; i_icb_cmd_ready = cmdr;
    i_icb_rsp_valid = rspv; i_icb_rsp_rdata = rdat; i_icb_rsp_err = rerr;
    i_inst_ready = instr; i_pipe_flush_req = flush;
    #1;
    credit = (m_outst + m_fifo.size()) < MAX;
    e_cv = pcv & credit & ~flush;
    e_pr = cmdr & credit & ~flush;
    chk("cmd_valid", o_icb_cmd_valid, e_cv);
    chk("pc_ready", o_pc_ready, e_pr);
    chk("cmd_addr", o_icb_cmd_addr, pc);
    chk("inst_valid", o_inst_valid, m_fifo.size() != 0);
    chk("busy", o_busy, (m_outst != 0) || (m_fifo.size() != 0));
    chk("disc_cnt", dut.r_disc_cnt, m_disc);
    if (m_fifo.size() != 0) begin
      chk("inst", o_inst, m_fifo[0].inst);
      chk("inst_pc", o_inst_pc, m_fifo[0].pc);
      chk("inst_err", o_inst_err, m_fifo[0].err);
    end
    if (o_icb_cmd_valid && cmdr) begin
      n_issue++;
      if (first_issue < 0) first_issue = cyc;
    end
    if (o_inst_valid && first_valid < 0) first_valid = cyc;
    if (o_inst_valid && instr && !flush) got.push_back(o_inst_pc);
    issue = e_cv & cmdr;
    pop   = (m_fifo.size() != 0) & instr;
    @(posedge clk);
    if (flush) begin
      m_disc = m_outst - int'(rspv);
      m_tq.delete();
      m_fifo.delete();
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (rspv) begin
        if (m_disc > 0) m_disc--;
        else begin
          e.inst = rdat; e.pc = m_tq.pop_front(); e.err = rerr;
          m_fifo.push_back(e);
        end
      end
      if (issue) m_tq.push_back(pc);
    end
    m_outst = m_outst + int'(issue) - int'(rspv);
    if (rspv) void'(bus_q.pop_front());
    if (issue) begin
      void'(src_q.pop_front());
      bus_q.push_back(pc);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[8];
    logic [31:0] w;
    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 32'hdead_beec, 1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 1'b1, 32'hffff_fffc, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0};
    cyc = 0; first_issue = -1; first_valid = -1; n_issue = 0;
    idle_inputs();
    rst_n = 1'b0;
    clr_model();
    #2;
    // Command path while held in reset: empty state, credit available.
    for (int i = 0; i < 8; i++) begin
      i_pc_valid = vt[i].pcv; i_icb_cmd_ready = vt[i].cmdr;
      i_pipe_flush_req = vt[i].flush; i_pc = vt[i].pc;
      #1;
      chk("tbl_cmd_valid", o_icb_cmd_valid, vt[i].e_cv);
      chk("tbl_pc_ready", o_pc_ready, vt[i].e_pr);
      chk("tbl_cmd_addr", o_icb_cmd_addr, vt[i].pc);
      chk("tbl_inst_valid", o_inst_valid, 1'b0);
      chk("tbl_busy", o_busy, 1'b0);
    end
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_inst_pc", o_inst_pc, 32'h0);
    chk("rst_inst_err", o_inst_err, 1'b0);
    chk("rsp_ready", o_icb_rsp_ready, 1'b1);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Three sequential fetches, bus latency 1, IFU always ready.
    got.delete(); first_issue = -1; first_valid = -1;
    src_q.push_back(32'h8000_0000); src_q.push_back(32'h8000_0004); src_q.push_back(32'h8000_0008);
    repeat (10) step(1, 1, 1, 0);
    chk("t1_count", got.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_pc_order", got_at(i), 32'h8000_0000 + 4 * i);
    chk("t1_first_valid_lat", first_valid - first_issue, 2);

    // IFU stalled: only MAX commands go out, nothing lost once it resumes.
    got.delete(); n_issue = 0;
    for (int i = 0; i < 4; i++) src_q.push_back(32'h8000_0020 + 4 * i);
    repeat (8) step(1, 1, 0, 0);
    chk("t2_issued", n_issue, 2);
    chk("t2_pc_ready_stall", o_pc_ready, 1'b0);
    repeat (12) step(1, 1, 1, 0);
    chk("t2_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_pc_order", got_at(i), 32'h8000_0020 + 4 * i);

    // Flush with two fetches in flight and no responses yet.
    got.delete();
    src_q.push_back(32'h8000_0040); src_q.push_back(32'h8000_0044);
    repeat (2) step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    chk("t3_disc_after_flush", dut.r_disc_cnt, 2);
    chk("t3_valid_after_flush", o_inst_valid, 1'b0);
    src_q.push_back(32'h8000_0100);
    repeat (8) step(1, 1, 1, 0);
    chk("t3_disc_drained", dut.r_disc_cnt, 0);
    chk("t3_count", got.size(), 1);
    chk("t3_pc", got_at(0), 32'h8000_0100);

    // Flush coinciding with a response and a pop.
    src_q.push_back(32'h8000_0050); src_q.push_back(32'h8000_0054);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("t4_buffered", o_inst_valid, 1'b1);
    step(1, 1, 1, 1);
    chk("t4_valid", o_inst_valid, 1'b0);
    chk("t4_disc", dut.r_disc_cnt, 0);
    chk("t4_busy", o_busy, 1'b0);

    // Bus error propagates with its PC.
    src_q.push_back(32'h8000_0010);
    repeat (3) step(1, 1, 0, 0);
    chk("t5_valid", o_inst_valid, 1'b1);
    chk("t5_pc", o_inst_pc, 32'h8000_0010);
    chk("t5_err", o_inst_err, 1'b1);
    repeat (2) step(1, 1, 1, 0);

    // Asynchronous reset with one fetch in flight and one buffered.
    src_q.push_back(32'h8000_0060); src_q.push_back(32'h8000_0064);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("t6_busy_before", o_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", o_inst_valid, 1'b0);
    chk("t6_async_busy", o_busy, 1'b0);
    do_reset();

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if (src_q.size() < 2 && $urandom_range(3) != 0) begin
        w = $urandom();
        w[1:0] = 2'b00;
        src_q.push_back(w);
      end
      step($urandom_range(3) != 0, $urandom_range(2) != 0,
           $urandom_range(2) != 0, $urandom_range(15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
